proc_gen: RTL

Parametrised successor of the 10-bit bus processor. A multicycle, single-bus CPU core with configurable data width and register count. It uses one shared accumulator/result pair (A/G) for every ALU operation, adds a zero flag with a conditional move, defines divide-by-zero behaviour, and resets its register file. It sits between the instruction/data source (DIN, Run) and the board-level display logic (Rdump, BusWires).

---
 rtl/proc_gen_if.sv | 26 ++
 rtl/proc_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/proc_gen_if.sv
// proc_gen bus/status bundle: run/instruction input side and
// done/bus/register-dump/flag output side.
interface proc_gen_if #(
  parameter int W  = 16,
  parameter int RA = 3
);
  localparam int NREG = 2**RA;

  logic              Run;
  logic [W-1:0]      DIN;
  logic              Done;
  logic [W-1:0]      BusWires;
  logic [NREG*W-1:0] Rdump;
  logic              Z;
  logic              DZ;

  modport master (
    output Run, DIN,
    input  Done, BusWires, Rdump, Z, DZ
  );

  modport slave (
    input  Run, DIN,
    output Done, BusWires, Rdump, Z, DZ
  );
endinterface

// File: rtl/proc_gen.sv
// proc_gen: multicycle single-bus CPU with shared A/G ALU path.
// Define PROC_GEN_MULDIV_EN to implement mul/div (else NOP, DZ=0).
module proc_gen #(
  parameter int W  = 16,
  parameter int RA = 3
) (
  input  logic       ClocK,
  input  logic       Resetn,
  proc_gen_if.slave  bus
);
  localparam int NREG = 2**RA;
  localparam int IW   = 4 + 2*RA;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t        r_state, w_next;
  logic [IW-1:0] r_ir;
  logic [W-1:0]  r_a, r_g;
  logic [W-1:0]  r_regs [NREG];
  logic          r_z;

  logic [3:0]    w_op;
  logic [RA-1:0] w_x, w_y;
  logic [W-1:0]  w_rx, w_ry, w_bus, w_res;
  logic          w_alu, w_mv, w_mvi, w_mvnz, w_done;

  assign w_op = r_ir[IW-1 -: 4];
  assign w_x  = r_ir[2*RA-1 -: RA];
  assign w_y  = r_ir[RA-1:0];
  assign w_rx = r_regs[w_x];
  assign w_ry = r_regs[w_y];

  always_comb begin
    w_alu  = 1'b0;
    w_mv   = 1'b0;
    w_mvi  = 1'b0;
    w_mvnz = 1'b0;
    unique case (w_op)
      4'h0: w_mv = 1'b1;
      4'h1: w_mvi = 1'b1;
      4'h2, 4'h3, 4'h4, 4'h5,
      4'h6, 4'h7, 4'hA, 4'hB: w_alu = 1'b1;
`ifdef PROC_GEN_MULDIV_EN
      4'h8, 4'h9: w_alu = 1'b1;
`endif
      4'hC: w_mvnz = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_bus  = bus.DIN;
    unique case (r_state)
      T0: if (bus.Run) w_next = T1;
      T1: begin
        if (w_alu) begin
          w_bus  = w_rx;
          w_next = T2;
        end else begin
          if (w_mv || w_mvnz) w_bus = w_ry;
          w_done = 1'b1;
          w_next = T0;
        end
      end
      T2: begin
        w_bus  = w_ry;
        w_next = T3;
      end
      T3: begin
        w_bus  = r_g;
        w_done = 1'b1;
        w_next = T0;
      end
    endcase
  end

  // Operand B is the bus, which carries Ry during T2
  always_comb begin
    w_res = '0;
    unique case (w_op)
      4'h2: w_res = r_a + w_bus;
      4'h3: w_res = r_a - w_bus;
      4'h4: w_res = r_a & w_bus;
      4'h5: w_res = r_a | w_bus;
      4'h6: w_res = r_a << w_bus;
      4'h7: w_res = r_a >> w_bus;
`ifdef PROC_GEN_MULDIV_EN
      4'h8: w_res = r_a * w_bus;
      4'h9: w_res = (w_bus == '0) ? '1 : r_a / w_bus;
`endif
      4'hA: w_res = r_a ^ w_bus;
      4'hB: w_res = ~(r_a ^ w_bus);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge ClocK or negedge Resetn) begin
    if (!Resetn) r_state <= T0;
    else         r_state <= w_next;
  end

  always_ff @(posedge ClocK or negedge Resetn) begin
    if (!Resetn) begin
      r_ir <= '0;
      r_a  <= '0;
      r_g  <= '0;
      r_z  <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        T0: r_ir <= bus.DIN[W-1 -: IW];
        T1: begin
          if (w_alu)
            r_a <= w_bus;
          else if (w_mv || w_mvi || (w_mvnz && !r_z))
            r_regs[w_x] <= w_bus;
        end
        T2: r_g <= w_res;
        T3: begin
          r_regs[w_x] <= r_g;
          r_z         <= (r_g == '0);
        end
      endcase
    end
  end

`ifdef PROC_GEN_MULDIV_EN
  logic r_dz;

  // Ry is still the divisor at T3; its write lands on this same edge
  always_ff @(posedge ClocK or negedge Resetn) begin
    if (!Resetn)
      r_dz <= 1'b0;
    else if (r_state == T3 && w_op == 4'h9)
      r_dz <= (w_ry == '0);
  end

  assign bus.DZ = r_dz;
`else
  assign bus.DZ = 1'b0;
`endif

  assign bus.Done     = w_done;
  assign bus.BusWires = w_bus;
  assign bus.Z        = r_z;

  for (genvar g = 0; g < NREG; g++) begin : g_dump
    assign bus.Rdump[g*W +: W] = r_regs[g];
  end
endmodule
